// File: rtl/credit_flowcontrol.sv
// Credit-based output port flow control for a wormhole router input: picks a
// downstream port round-robin for head flits and holds it until the tail.
module credit_flowcontrol #(
  parameter int NPORTS = 5,
  parameter int DEPTH  = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NPORTS-1:0]         port_sel,
  input  logic                      flit_valid,
  input  logic                      flit_head,
  input  logic                      flit_tail,
  input  logic [NPORTS-1:0]         credit_in,
  output logic [NPORTS-1:0]         ready_out,
  output logic [NPORTS*CNT_W-1:0]   credit_cnt,
  output logic                      locked,
  output logic [NPORTS-1:0]         lock_port,
  output logic                      err_ovf
);

  localparam int PTR_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam logic [PTR_W:0]   NP_C    = (PTR_W + 1)'(NPORTS);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                  state_q;
  logic [PTR_W-1:0]        rr_ptr_q;
  logic [NPORTS-1:0]       lock_port_q;
  logic                    locked_q;
  logic                    err_ovf_q;
  logic [CNT_W-1:0]        credit_q [NPORTS];
  logic [CNT_W-1:0]        credit_d [NPORTS];

  logic [NPORTS-1:0]       avail;
  logic [NPORTS-1:0]       cand;
  logic [NPORTS-1:0]       sent;
  logic [NPORTS-1:0]       ovf_hit;
  logic [NPORTS-1:0]       grant;
  logic [PTR_W-1:0]        rr_ptr_d;
  logic                    transfer;

  always_comb begin
    for (int i = 0; i < NPORTS; i++) begin
      avail[i] = (credit_q[i] != '0);
    end
  end

  assign cand = port_sel & avail;

  // Rotate candidates so rr_ptr sits at bit 0, pick the lowest set bit, rotate back.
  always_comb begin
    logic [2*NPORTS-1:0] rot;
    logic [2*NPORTS-1:0] back;
    logic [NPORTS-1:0]   first;
    logic [PTR_W:0]      idx;
    logic                found;
    rot   = {cand, cand} >> rr_ptr_q;
    first = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < NPORTS; k++) begin
      if (!found && rot[k]) begin
        found    = 1'b1;
        first[k] = 1'b1;
        idx      = {1'b0, rr_ptr_q} + (PTR_W + 1)'(k);
      end
    end
    back  = {{NPORTS{1'b0}}, first} << rr_ptr_q;
    grant = back[NPORTS-1:0] | back[2*NPORTS-1:NPORTS];
    if (idx >= NP_C) begin
      idx = idx - NP_C;
    end
    idx = idx + (PTR_W + 1)'(1);
    if (idx >= NP_C) begin
      idx = idx - NP_C;
    end
    rr_ptr_d = idx[PTR_W-1:0];
  end

  always_comb begin
    ready_out = '0;
    if (rst) begin
      ready_out = '0;
    end else if (state_q == LOCKED) begin
      ready_out = lock_port_q & avail;
    end else if (flit_valid && flit_head) begin
      ready_out = grant;
    end
  end

  assign sent     = ready_out & {NPORTS{flit_valid}};
  assign transfer = |sent;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      lock_port_q <= '0;
      locked_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (transfer) begin
            rr_ptr_q <= rr_ptr_d;
            if (!flit_tail) begin
              state_q     <= LOCKED;
              lock_port_q <= ready_out;
              locked_q    <= 1'b1;
            end
          end
        end
        LOCKED: begin
          if (transfer && flit_tail) begin
            state_q     <= IDLE;
            lock_port_q <= '0;
            locked_q    <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          lock_port_q <= '0;
          locked_q    <= 1'b0;
        end
      endcase
    end
  end

  // A return with a full counter and no send is a downstream protocol error: hold and flag.
  always_comb begin
    ovf_hit = '0;
    for (int i = 0; i < NPORTS; i++) begin
      credit_d[i] = credit_q[i];
      if (credit_in[i] && !sent[i]) begin
        if (credit_q[i] == DEPTH_C) begin
          ovf_hit[i] = 1'b1;
        end else begin
          credit_d[i] = credit_q[i] + CNT_W'(1);
        end
      end else if (sent[i] && !credit_in[i]) begin
        credit_d[i] = credit_q[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NPORTS; i++) begin
        credit_q[i] <= DEPTH_C;
      end
      err_ovf_q <= 1'b0;
    end else begin
      for (int i = 0; i < NPORTS; i++) begin
        credit_q[i] <= credit_d[i];
      end
      if (|ovf_hit) begin
        err_ovf_q <= 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NPORTS; i++) begin
      credit_cnt[i*CNT_W +: CNT_W] = credit_q[i];
    end
  end

  assign locked    = locked_q;
  assign lock_port = lock_port_q;
  assign err_ovf   = err_ovf_q;

endmodule

// File: tb/tb_credit_flowcontrol.sv
// Directed bench for credit_flowcontrol with the default 5 ports, depth 4.
module tb_credit_flowcontrol;

  localparam int NPORTS = 5;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 3;

  logic                    clk;
  logic                    rst;
  logic [NPORTS-1:0]       port_sel;
  logic                    flit_valid;
  logic                    flit_head;
  logic                    flit_tail;
  logic [NPORTS-1:0]       credit_in;
  logic [NPORTS-1:0]       ready_out;
  logic [NPORTS*CNT_W-1:0] credit_cnt;
  logic                    locked;
  logic [NPORTS-1:0]       lock_port;
  logic                    err_ovf;

  int checks = 0;
  int errors = 0;

  credit_flowcontrol #(.NPORTS(NPORTS), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .port_sel   (port_sel),
    .flit_valid (flit_valid),
    .flit_head  (flit_head),
    .flit_tail  (flit_tail),
    .credit_in  (credit_in),
    .ready_out  (ready_out),
    .credit_cnt (credit_cnt),
    .locked     (locked),
    .lock_port  (lock_port),
    .err_ovf    (err_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cred(input int p);
    return 32'((credit_cnt >> (p * CNT_W)) & 15'h7);
  endfunction

  task automatic drive(input logic v, input logic h, input logic t,
                       input logic [NPORTS-1:0] sel, input logic [NPORTS-1:0] cin);
    flit_valid = v;
    flit_head  = h;
    flit_tail  = t;
    port_sel   = sel;
    credit_in  = cin;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] ALL_FULL = 32'h4924;

  initial begin
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 5'b00100, 5'b00000);
    #1;
    chk("ready_in_reset", 32'(ready_out), 32'h0);
    tick();
    chk("rst_credits", 32'(credit_cnt), ALL_FULL);
    chk("rst_locked", 32'(locked), 32'h0);
    chk("rst_lock_port", 32'(lock_port), 32'h0);
    chk("rst_err", 32'(err_ovf), 32'h0);
    chk("rst_rr", 32'(dut.rr_ptr_q), 32'h0);

    // Single-flit packet to E, same-cycle grant
    rst = 1'b0;
    #1;
    chk("e_grant", 32'(ready_out), 32'h04);
    tick();
    chk("e_credit3", cred(2), 32'd3);
    chk("e_rr3", 32'(dut.rr_ptr_q), 32'd3);
    chk("e_unlocked", 32'(locked), 32'h0);
    drive(1'b0, 1'b0, 1'b0, 5'b00000, 5'b00100);
    tick();
    chk("e_restored", cred(2), 32'd4);

    // Round-robin wraps from rr=3 past W,S to L
    drive(1'b1, 1'b1, 1'b1, 5'b00011, 5'b00000);
    #1;
    chk("wrap_grant_L", 32'(ready_out), 32'h01);
    tick();
    chk("wrap_rr1", 32'(dut.rr_ptr_q), 32'd1);
    chk("wrap_L3", cred(0), 32'd3);
    drive(1'b0, 1'b0, 1'b0, 5'b00000, 5'b00001);
    tick();

    // Multi-flit packet locked to N
    rst = 1'b1;
    #1;
    chk("rst2_rr", 32'(dut.rr_ptr_q), 32'h0);
    chk("rst2_credits", 32'(credit_cnt), ALL_FULL);
    rst = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 5'b00110, 5'b00000);
    #1;
    chk("n_head_grant", 32'(ready_out), 32'h02);
    tick();
    chk("n_locked", 32'(locked), 32'h1);
    chk("n_lock_port", 32'(lock_port), 32'h02);
    chk("n_credit3", cred(1), 32'd3);
    chk("n_rr2", 32'(dut.rr_ptr_q), 32'd2);
    for (int b = 0; b < 3; b++) begin
      drive(1'b1, 1'b0, 1'b0, 5'b00100, 5'b00010);
      #1;
      chk("n_body_grant", 32'(ready_out), 32'h02);
      tick();
      chk("n_body_credit", cred(1), 32'd3);
      chk("n_body_locked", 32'(locked), 32'h1);
    end
    drive(1'b1, 1'b0, 1'b1, 5'b00100, 5'b00000);
    #1;
    chk("n_tail_grant", 32'(ready_out), 32'h02);
    tick();
    chk("n_tail_unlock", 32'(locked), 32'h0);
    chk("n_tail_lockport", 32'(lock_port), 32'h0);
    chk("n_tail_credit", cred(1), 32'd2);
    chk("n_tail_rr", 32'(dut.rr_ptr_q), 32'd2);
    drive(1'b0, 1'b0, 1'b0, 5'b00000, 5'b00010);
    tick();
    tick();
    chk("n_restored", cred(1), 32'd4);

    // Exhaust W credits, then one return re-enables it
    for (int f = 0; f < 4; f++) begin
      drive(1'b1, 1'b1, 1'b1, 5'b01000, 5'b00000);
      #1;
      chk("w_grant", 32'(ready_out), 32'h08);
      tick();
      chk("w_credit", cred(3), 32'(3 - f));
    end
    chk("w_blocked", 32'(ready_out), 32'h0);
    tick();
    chk("w_still_blocked", 32'(ready_out), 32'h0);
    drive(1'b1, 1'b1, 1'b1, 5'b01000, 5'b01000);
    #1;
    chk("w_no_comb_credit", 32'(ready_out), 32'h0);
    tick();
    chk("w_credit1", cred(3), 32'd1);
    drive(1'b1, 1'b1, 1'b1, 5'b01000, 5'b00000);
    #1;
    chk("w_regrant", 32'(ready_out), 32'h08);
    tick();
    chk("w_credit0", cred(3), 32'd0);

    // Overflow on L; simultaneous send and return on S
    drive(1'b0, 1'b0, 1'b0, 5'b00000, 5'b00001);
    tick();
    chk("ovf_L_hold", cred(0), 32'd4);
    chk("ovf_set", 32'(err_ovf), 32'h1);
    drive(1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000);
    tick();
    chk("ovf_sticky", 32'(err_ovf), 32'h1);
    drive(1'b1, 1'b1, 1'b1, 5'b10000, 5'b10000);
    #1;
    chk("s_grant", 32'(ready_out), 32'h10);
    tick();
    chk("s_unchanged", cred(4), 32'd4);
    chk("ovf_still", 32'(err_ovf), 32'h1);
    drive(1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000);

    // Reset mid-packet abandons the lock
    rst = 1'b1;
    #1;
    chk("ovf_cleared", 32'(err_ovf), 32'h0);
    rst = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 5'b00100, 5'b00000);
    #1;
    chk("e2_head_grant", 32'(ready_out), 32'h04);
    tick();
    drive(1'b1, 1'b0, 1'b0, 5'b00011, 5'b00000);
    tick();
    tick();
    chk("e2_credit1", cred(2), 32'd1);
    chk("e2_locked", 32'(locked), 32'h1);
    chk("e2_lock_port", 32'(lock_port), 32'h04);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_locked", 32'(locked), 32'h0);
    chk("midrst_credits", 32'(credit_cnt), ALL_FULL);
    chk("midrst_rr", 32'(dut.rr_ptr_q), 32'h0);
    chk("midrst_ready", 32'(ready_out), 32'h0);
    chk("midrst_lockport", 32'(lock_port), 32'h0);
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 5'b00100, 5'b00000);
    #1;
    chk("body_after_rst", 32'(ready_out), 32'h0);
    tick();
    chk("body_after_rst_E", cred(2), 32'd4);
    chk("body_after_rst_lk", 32'(locked), 32'h0);
    drive(1'b1, 1'b1, 1'b1, 5'b00100, 5'b00000);
    #1;
    chk("head_after_rst", 32'(ready_out), 32'h04);
    tick();
    drive(1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
